// File: rtl/utest_monitor_pkg.sv
// Shared types and opcode field layout for the microcode self-test checkpoint monitor.
// Pure declarations: no latency and no flow control.
package utest_monitor_pkg;

  localparam int OP_SQI_MSB = 112;
  localparam int OP_SQI_LSB = 109;
  localparam int OP_A_MSB   = 108;
  localparam int OP_A_LSB   = 97;
  localparam int OP_MAP_MSB = 96;
  localparam int OP_MAP_LSB = 95;

  localparam int SQI_W  = OP_SQI_MSB - OP_SQI_LSB + 1;
  localparam int MAP_W  = OP_MAP_MSB - OP_MAP_LSB + 1;
  localparam int OP_A_W = OP_A_MSB - OP_A_LSB + 1;

  localparam logic [SQI_W-1:0] SQI_CONT = SQI_W'(14);
  localparam logic [MAP_W-1:0] MAP_PE   = MAP_W'(0);

  typedef enum logic [1:0] {
    PASS = 2'd0,
    SKIP = 2'd1,
    FAIL = 2'd2,
    DONE = 2'd3
  } kind_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PASSED = 2'd2,
    S_FAILED = 2'd3
  } state_t;

  // A pass checkpoint is a CONT sequencer op whose map field selects the PE map.
  function automatic logic is_cont(input logic [SQI_W-1:0] sqi, input logic [MAP_W-1:0] map);
    return (sqi == SQI_CONT) && (map == MAP_PE);
  endfunction

endpackage

// File: rtl/utest_match.sv
// Parallel two-field comparator bank; reports the lowest enabled matching entry.
// Purely combinational (zero latency); no flow control.
module utest_match #(
  parameter int N     = 4,
  parameter int W     = 12,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]          en,
  input  logic [N-1:0][W-1:0]   key_a,
  input  logic [N-1:0][W-1:0]   key_b,
  input  logic [W-1:0]          val_a,
  input  logic [W-1:0]          val_b,
  output logic                  hit,
  output logic [IDX_W-1:0]      idx
);

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (en[i] && (key_a[i] == val_a) && (key_b[i] == val_b)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/utest_monitor.sv
// Microcode self-test checkpoint monitor: pass/fail/done labels, skip redirects, cycle limit.
// All outputs registered (match at T -> output at T+1); no backpressure. UTEST_MONITOR_COVER_EN adds cover_map.
module utest_monitor
  import utest_monitor_pkg::*;
#(
  parameter int PC_W    = OP_A_W,
  parameter int N_PASS  = 64,
  parameter int N_SKIP  = 16,
  parameter int N_FAIL  = 4,
  parameter int LIMIT_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               arm,
  input  logic [LIMIT_W-1:0] limit,
  input  logic               x_valid,
  input  logic [PC_W-1:0]    pc_x,
  input  logic [PC_W-1:0]    pc_f,
  input  logic [SQI_W-1:0]   op_sqi,
  input  logic [MAP_W-1:0]   op_map,
  input  logic [PC_W-1:0]    op_a,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_kind,
  input  logic [5:0]         cfg_idx,
  input  logic               cfg_en,
  input  logic [PC_W-1:0]    cfg_a,
  input  logic [PC_W-1:0]    cfg_b,
  input  logic [PC_W-1:0]    cfg_c,
  output logic               redir_valid,
  output logic [PC_W-1:0]    redir_addr,
  output logic               pass_hit,
  output logic [5:0]         pass_idx,
  output logic [15:0]        pass_count,
  output logic [1:0]         state,
  output logic               timeout,
`ifdef UTEST_MONITOR_COVER_EN
  output logic [N_PASS-1:0]  cover_map,
`endif
  output logic [1:0]         fail_idx
);

  localparam int PI_W = (N_PASS > 1) ? $clog2(N_PASS) : 1;
  localparam int SI_W = (N_SKIP > 1) ? $clog2(N_SKIP) : 1;
  localparam int FI_W = (N_FAIL > 1) ? $clog2(N_FAIL) : 1;

  logic [N_PASS-1:0]           pass_en_q;
  logic [N_PASS-1:0][PC_W-1:0] pass_a_q;
  logic [N_SKIP-1:0]           skip_en_q;
  logic [N_SKIP-1:0][PC_W-1:0] skip_from_q;
  logic [N_SKIP-1:0][PC_W-1:0] skip_to_q;
  logic [N_SKIP-1:0][PC_W-1:0] skip_tgt_q;
  logic [N_FAIL-1:0]           fail_en_q;
  logic [N_FAIL-1:0][PC_W-1:0] fail_a_q;
  logic                        done_en_q;
  logic [PC_W-1:0]             done_a_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pass_en_q   <= '0;
      pass_a_q    <= '0;
      skip_en_q   <= '0;
      skip_from_q <= '0;
      skip_to_q   <= '0;
      skip_tgt_q  <= '0;
      fail_en_q   <= '0;
      fail_a_q    <= '0;
      done_en_q   <= 1'b0;
      done_a_q    <= '0;
    end else if (cfg_we) begin
      unique case (kind_t'(cfg_kind))
        PASS: begin
          for (int i = 0; i < N_PASS; i++) begin
            if (int'(cfg_idx) == i) begin
              pass_en_q[i] <= cfg_en;
              pass_a_q[i]  <= cfg_a;
            end
          end
        end
        SKIP: begin
          for (int i = 0; i < N_SKIP; i++) begin
            if (int'(cfg_idx) == i) begin
              skip_en_q[i]   <= cfg_en;
              skip_from_q[i] <= cfg_a;
              skip_to_q[i]   <= cfg_b;
              skip_tgt_q[i]  <= cfg_c;
            end
          end
        end
        FAIL: begin
          for (int i = 0; i < N_FAIL; i++) begin
            if (int'(cfg_idx) == i) begin
              fail_en_q[i] <= cfg_en;
              fail_a_q[i]  <= cfg_a;
            end
          end
        end
        DONE: begin
          done_en_q <= cfg_en;
          done_a_q  <= cfg_a;
        end
      endcase
    end
  end

  logic             pm_hit, sm_hit, fm_hit, done_hit;
  logic [PI_W-1:0]  pm_idx;
  logic [SI_W-1:0]  sm_idx;
  logic [FI_W-1:0]  fm_idx;
  logic             pass_first;
  logic             pass_ok;

  utest_match #(.N(N_PASS), .W(PC_W), .IDX_W(PI_W)) u_pass_match (
    .en(pass_en_q), .key_a(pass_a_q), .key_b(pass_a_q),
    .val_a(op_a), .val_b(op_a), .hit(pm_hit), .idx(pm_idx)
  );

  utest_match #(.N(N_SKIP), .W(PC_W), .IDX_W(SI_W)) u_skip_match (
    .en(skip_en_q), .key_a(skip_from_q), .key_b(skip_to_q),
    .val_a(pc_x), .val_b(pc_f), .hit(sm_hit), .idx(sm_idx)
  );

  utest_match #(.N(N_FAIL), .W(PC_W), .IDX_W(FI_W)) u_fail_match (
    .en(fail_en_q), .key_a(fail_a_q), .key_b(fail_a_q),
    .val_a(pc_x), .val_b(pc_x), .hit(fm_hit), .idx(fm_idx)
  );

  assign done_hit = done_en_q && (pc_x == done_a_q);
  assign pass_ok  = pm_hit && is_cont(op_sqi, op_map) && pass_first;

  state_t             state_q, state_d;
  logic [LIMIT_W-1:0] cnt_q, cnt_d;
  logic               lim_en_q, lim_en_d;
  logic               blk_q, blk_d;
  logic               redir_vld_q, redir_vld_d;
  logic [PC_W-1:0]    redir_addr_q, redir_addr_d;
  logic               pass_hit_q, pass_hit_d;
  logic [5:0]         pass_idx_q, pass_idx_d;
  logic [15:0]        pass_cnt_q, pass_cnt_d;
  logic               timeout_q, timeout_d;
  logic [1:0]         fail_idx_q, fail_idx_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lim_en_d     = lim_en_q;
    blk_d        = 1'b0;
    redir_vld_d  = 1'b0;
    redir_addr_d = redir_addr_q;
    pass_hit_d   = 1'b0;
    pass_idx_d   = pass_idx_q;
    pass_cnt_d   = pass_cnt_q;
    timeout_d    = timeout_q;
    fail_idx_d   = fail_idx_q;

    if (arm) begin
      state_d    = S_RUN;
      cnt_d      = limit;
      lim_en_d   = (limit != '0);
      pass_cnt_d = '0;
      timeout_d  = 1'b0;
      fail_idx_d = '0;
    end else if (state_q == S_RUN) begin
      // The cycle after a redirect carries a wrong-path instruction, so nothing matches.
      if (x_valid && !blk_q) begin
        if (fm_hit) begin
          state_d    = S_FAILED;
          fail_idx_d = 2'(fm_idx);
        end else if (done_hit) begin
          state_d = S_PASSED;
        end else if (sm_hit) begin
          redir_vld_d  = 1'b1;
          redir_addr_d = skip_tgt_q[sm_idx];
          blk_d        = 1'b1;
        end else if (pass_ok) begin
          pass_hit_d = 1'b1;
          pass_idx_d = 6'(pm_idx);
          if (pass_cnt_q != 16'hFFFF) pass_cnt_d = pass_cnt_q + 16'd1;
        end
      end
      // Same-cycle FAIL/DONE already left RUN and therefore outrank the timeout.
      if (lim_en_q) begin
        cnt_d = cnt_q - LIMIT_W'(1);
        if ((cnt_q == LIMIT_W'(1)) && (state_d == S_RUN)) begin
          timeout_d = 1'b1;
          state_d   = S_FAILED;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      lim_en_q     <= 1'b0;
      blk_q        <= 1'b0;
      redir_vld_q  <= 1'b0;
      redir_addr_q <= '0;
      pass_hit_q   <= 1'b0;
      pass_idx_q   <= '0;
      pass_cnt_q   <= '0;
      timeout_q    <= 1'b0;
      fail_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lim_en_q     <= lim_en_d;
      blk_q        <= blk_d;
      redir_vld_q  <= redir_vld_d;
      redir_addr_q <= redir_addr_d;
      pass_hit_q   <= pass_hit_d;
      pass_idx_q   <= pass_idx_d;
      pass_cnt_q   <= pass_cnt_d;
      timeout_q    <= timeout_d;
      fail_idx_q   <= fail_idx_d;
    end
  end

`ifdef UTEST_MONITOR_COVER_EN
  logic [N_PASS-1:0] cover_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cover_q <= '0;
    end else if (arm) begin
      cover_q <= '0;
    end else if (pass_hit_d) begin
      cover_q[pm_idx] <= 1'b1;
    end
  end

  assign pass_first = !cover_q[pm_idx];
  assign cover_map  = cover_q;
`else
  assign pass_first = 1'b1;
`endif

  assign redir_valid = redir_vld_q;
  assign redir_addr  = redir_addr_q;
  assign pass_hit    = pass_hit_q;
  assign pass_idx    = pass_idx_q;
  assign pass_count  = pass_cnt_q;
  assign state       = state_q;
  assign timeout     = timeout_q;
  assign fail_idx    = fail_idx_q;

endmodule

// File: tb/tb_utest_monitor.sv
// Bench for utest_monitor: directed scenarios plus randomized traffic against a behavioural model.
module tb_utest_monitor;

  localparam int PC_W   = 12;
  localparam int N_PASS = 64;
  localparam int N_SKIP = 16;
  localparam int N_FAIL = 4;
  localparam int K_PASS = 0, K_SKIP = 1, K_FAIL = 2, K_DONE = 3;
`ifdef UTEST_MONITOR_COVER_EN
  localparam bit COVER = 1'b1;
`else
  localparam bit COVER = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            arm = 1'b0;
  logic [31:0]     limit = '0;
  logic            x_valid = 1'b0;
  logic [PC_W-1:0] pc_x = '0, pc_f = '0, op_a = '0;
  logic [3:0]      op_sqi = '0;
  logic [1:0]      op_map = '0;
  logic            cfg_we = 1'b0, cfg_en = 1'b0;
  logic [1:0]      cfg_kind = '0;
  logic [5:0]      cfg_idx = '0;
  logic [PC_W-1:0] cfg_a = '0, cfg_b = '0, cfg_c = '0;
  logic            redir_valid, pass_hit, timeout;
  logic [PC_W-1:0] redir_addr;
  logic [5:0]      pass_idx;
  logic [15:0]     pass_count;
  logic [1:0]      state, fail_idx;
`ifdef UTEST_MONITOR_COVER_EN
  logic [N_PASS-1:0] cover_map;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  utest_monitor dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .limit(limit),
    .x_valid(x_valid), .pc_x(pc_x), .pc_f(pc_f),
    .op_sqi(op_sqi), .op_map(op_map), .op_a(op_a),
    .cfg_we(cfg_we), .cfg_kind(cfg_kind), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_c(cfg_c),
    .redir_valid(redir_valid), .redir_addr(redir_addr),
    .pass_hit(pass_hit), .pass_idx(pass_idx), .pass_count(pass_count),
    .state(state), .timeout(timeout),
`ifdef UTEST_MONITOR_COVER_EN
    .cover_map(cover_map),
`endif
    .fail_idx(fail_idx)
  );

  // Reference model: labelled tables plus the observable status of the monitor.
  bit    m_pass_en[N_PASS];  int m_pass_a[N_PASS];  bit m_cover[N_PASS];
  bit    m_skip_en[N_SKIP];  int m_skip_f[N_SKIP];  int m_skip_t[N_SKIP];  int m_skip_g[N_SKIP];
  bit    m_fail_en[N_FAIL];  int m_fail_a[N_FAIL];
  bit    m_done_en;          int m_done_a;
  int    m_state, m_fidx, m_pidx, m_pcnt, m_raddr;
  bit    m_tmo, m_hit, m_redir, m_block, m_limited;
  longint m_left;

  function automatic void model_clear();
    foreach (m_pass_en[i]) begin m_pass_en[i] = 0; m_pass_a[i] = 0; m_cover[i] = 0; end
    foreach (m_skip_en[i]) begin m_skip_en[i] = 0; m_skip_f[i] = 0; m_skip_t[i] = 0; m_skip_g[i] = 0; end
    foreach (m_fail_en[i]) begin m_fail_en[i] = 0; m_fail_a[i] = 0; end
    m_done_en = 0; m_done_a = 0;
    m_state = 0; m_fidx = 0; m_pidx = 0; m_pcnt = 0; m_raddr = 0;
    m_tmo = 0; m_hit = 0; m_redir = 0; m_block = 0; m_limited = 0; m_left = 0;
  endfunction

  function automatic int first_pass(input int a);
    for (int i = 0; i < N_PASS; i++) if (m_pass_en[i] && m_pass_a[i] == a) return i;
    return -1;
  endfunction

  function automatic int first_skip(input int x, input int f);
    for (int i = 0; i < N_SKIP; i++) if (m_skip_en[i] && m_skip_f[i] == x && m_skip_t[i] == f) return i;
    return -1;
  endfunction

  function automatic int first_fail(input int x);
    for (int i = 0; i < N_FAIL; i++) if (m_fail_en[i] && m_fail_a[i] == x) return i;
    return -1;
  endfunction

  // Advance the model with the inputs currently driven, then clock the DUT.
  task automatic tick();
    bit blk;
    int f, s, p;
    blk = m_block;
    m_redir = 0; m_hit = 0; m_block = 0;
    if (arm) begin
      m_state = 1; m_pcnt = 0; m_tmo = 0; m_fidx = 0;
      m_left = limit; m_limited = (limit != 0);
      foreach (m_cover[i]) m_cover[i] = 0;
    end else if (m_state == 1) begin
      if (x_valid && !blk) begin
        f = first_fail(int'(pc_x));
        s = first_skip(int'(pc_x), int'(pc_f));
        p = first_pass(int'(op_a));
        if (f >= 0) begin
          m_state = 3; m_fidx = f;
        end else if (m_done_en && m_done_a == int'(pc_x)) begin
          m_state = 2;
        end else if (s >= 0) begin
          m_redir = 1; m_raddr = m_skip_g[s]; m_block = 1;
        end else if (p >= 0 && op_sqi == 4'd14 && op_map == 2'd0 && !(COVER && m_cover[p])) begin
          m_hit = 1; m_pidx = p; m_cover[p] = 1;
          if (m_pcnt < 65535) m_pcnt++;
        end
      end
      if (m_limited) begin
        m_left--;
        if (m_left == 0 && m_state == 1) begin m_tmo = 1; m_state = 3; end
      end
    end
    if (cfg_we) begin
      case (int'(cfg_kind))
        K_PASS: if (cfg_idx < N_PASS) begin m_pass_en[cfg_idx] = cfg_en; m_pass_a[cfg_idx] = int'(cfg_a); end
        K_SKIP: if (cfg_idx < N_SKIP) begin
          m_skip_en[cfg_idx] = cfg_en; m_skip_f[cfg_idx] = int'(cfg_a);
          m_skip_t[cfg_idx] = int'(cfg_b); m_skip_g[cfg_idx] = int'(cfg_c);
        end
        K_FAIL: if (cfg_idx < N_FAIL) begin m_fail_en[cfg_idx] = cfg_en; m_fail_a[cfg_idx] = int'(cfg_a); end
        default: begin m_done_en = cfg_en; m_done_a = int'(cfg_a); end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    x_valid = 0; pc_x = '0; pc_f = '0; op_sqi = '0; op_map = '0; op_a = '0; arm = 0; cfg_we = 0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 0;
    model_clear();
    @(posedge clk); #1;
    reset_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic cfg(input int kind, input int idx, input bit en, input int a, input int b = 0, input int c = 0);
    cfg_we = 1; cfg_kind = 2'(kind); cfg_idx = 6'(idx); cfg_en = en;
    cfg_a = PC_W'(a); cfg_b = PC_W'(b); cfg_c = PC_W'(c);
    tick();
    cfg_we = 0;
  endtask

  task automatic do_arm(input int lim);
    arm = 1; limit = 32'(lim);
    tick();
    arm = 0;
  endtask

  task automatic drive_pass(input int a);
    x_valid = 1; pc_x = 12'd100; op_sqi = 4'd14; op_map = 2'd0; op_a = PC_W'(a);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({redir_valid, redir_addr, pass_hit, pass_idx, pass_count, state, timeout, fail_idx} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h expected 0",
               {redir_valid, redir_addr, pass_hit, pass_idx, pass_count, state, timeout, fail_idx});
    end
`ifdef UTEST_MONITOR_COVER_EN
    n_cmp++;
    if (cover_map !== '0) begin n_bad++; $display("FAIL reset_cover: got %h expected 0", cover_map); end
`endif
  endtask

  task automatic test_skip();
    do_reset();
    cfg(K_SKIP, 0, 1, 0, 1, 1096);
    do_arm(0);
    x_valid = 1; pc_x = 12'd0; pc_f = 12'd1;
    tick();
    n_cmp++;
    if (redir_valid !== 1'b1 || redir_addr !== 12'd1096) begin
      n_bad++; $display("FAIL skip_redirect: got v=%b a=%0d expected v=1 a=1096", redir_valid, redir_addr);
    end
    tick();
    n_cmp++;
    if (redir_valid !== 1'b0) begin n_bad++; $display("FAIL skip_blocked: got %b expected 0", redir_valid); end
    tick();
    n_cmp++;
    if (redir_valid !== 1'b1) begin n_bad++; $display("FAIL skip_rematch: got %b expected 1", redir_valid); end
    x_valid = 0;
    tick();
    n_cmp++;
    if (redir_valid !== 1'b0 || state !== 2'd1) begin
      n_bad++; $display("FAIL skip_idle: got v=%b st=%0d expected v=0 st=1", redir_valid, state);
    end
  endtask

  task automatic test_pass();
    do_reset();
    cfg(K_PASS, 3, 1, 12);
    do_arm(0);
    drive_pass(12);
    tick();
    n_cmp++;
    if (pass_hit !== 1'b1 || pass_idx !== 6'd3 || pass_count !== 16'd1) begin
      n_bad++; $display("FAIL pass_hit: got h=%b i=%0d c=%0d expected h=1 i=3 c=1", pass_hit, pass_idx, pass_count);
    end
    op_map = 2'd1;
    tick();
    n_cmp++;
    if (pass_hit !== 1'b0 || pass_count !== 16'd1) begin
      n_bad++; $display("FAIL pass_map1: got h=%b c=%0d expected h=0 c=1", pass_hit, pass_count);
    end
    op_map = 2'd0; op_sqi = 4'd13;
    tick();
    n_cmp++;
    if (pass_hit !== 1'b0) begin n_bad++; $display("FAIL pass_sqi13: got %b expected 0", pass_hit); end
  endtask

  task automatic test_repeat_hits();
    do_reset();
    cfg(K_PASS, 5, 1, 40);
    cfg(K_PASS, 63, 1, 41);
    do_arm(0);
    drive_pass(40);
    repeat (3) tick();
    n_cmp++;
    if (pass_count !== (COVER ? 16'd1 : 16'd3)) begin
      n_bad++; $display("FAIL repeat_count: got %0d expected %0d", pass_count, COVER ? 1 : 3);
    end
    op_a = 12'd41;
    tick();
    n_cmp++;
    if (pass_hit !== 1'b1 || pass_idx !== 6'd63) begin
      n_bad++; $display("FAIL pass_top_idx: got h=%b i=%0d expected h=1 i=63", pass_hit, pass_idx);
    end
`ifdef UTEST_MONITOR_COVER_EN
    n_cmp++;
    if (cover_map !== 64'h8000_0000_0000_0020) begin
      n_bad++; $display("FAIL cover_map: got %h expected 8000000000000020", cover_map);
    end
`endif
  endtask

  task automatic test_fail();
    do_reset();
    cfg(K_FAIL, 0, 1, 1665);
    cfg(K_PASS, 3, 1, 12);
    cfg(K_FAIL, 4, 1, 33);
    do_arm(0);
    drive_pass(7); pc_x = 12'd33;
    tick();
    n_cmp++;
    if (state !== 2'd1) begin n_bad++; $display("FAIL fail_idx_oob: got st=%0d expected 1", state); end
    pc_x = 12'd1665; op_a = 12'd12;
    tick();
    n_cmp++;
    if (state !== 2'd3 || fail_idx !== 2'd0 || pass_hit !== 1'b0 || pass_count !== 16'd0) begin
      n_bad++; $display("FAIL fail_vs_pass: got st=%0d fi=%0d h=%b c=%0d expected 3 0 0 0",
                        state, fail_idx, pass_hit, pass_count);
    end
    pc_x = 12'd100;
    tick();
    n_cmp++;
    if (state !== 2'd3 || pass_hit !== 1'b0) begin
      n_bad++; $display("FAIL fail_terminal: got st=%0d h=%b expected 3 0", state, pass_hit);
    end
    idle();
    cfg(K_FAIL, 2, 1, 700);
    do_arm(0);
    x_valid = 1; pc_x = 12'd700;
    tick();
    n_cmp++;
    if (state !== 2'd3 || fail_idx !== 2'd2) begin
      n_bad++; $display("FAIL fail_idx2: got st=%0d fi=%0d expected 3 2", state, fail_idx);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    cfg(K_DONE, 0, 1, 1563);
    do_arm(100);
    repeat (99) tick();
    n_cmp++;
    if (state !== 2'd1 || timeout !== 1'b0) begin
      n_bad++; $display("FAIL timeout_early: got st=%0d t=%b expected 1 0", state, timeout);
    end
    tick();
    n_cmp++;
    if (state !== 2'd3 || timeout !== 1'b1) begin
      n_bad++; $display("FAIL timeout_100: got st=%0d t=%b expected 3 1", state, timeout);
    end
    do_arm(5);
    repeat (4) tick();
    x_valid = 1; pc_x = 12'd1563;
    tick();
    n_cmp++;
    if (state !== 2'd2 || timeout !== 1'b0) begin
      n_bad++; $display("FAIL done_over_timeout: got st=%0d t=%b expected 2 0", state, timeout);
    end
    idle();
    do_arm(0);
    repeat (20000) tick();
    n_cmp++;
    if (state !== 2'd1 || timeout !== 1'b0) begin
      n_bad++; $display("FAIL unlimited: got st=%0d t=%b expected 1 0", state, timeout);
    end
  endtask

  task automatic test_done();
    do_reset();
    cfg(K_DONE, 37, 1, 1563);
    cfg(K_PASS, 0, 1, 12);
    do_arm(0);
    drive_pass(12);
    tick();
    op_sqi = 4'd0; pc_x = 12'd1563;
    tick();
    n_cmp++;
    if (state !== 2'd2 || pass_count !== 16'd1) begin
      n_bad++; $display("FAIL done: got st=%0d c=%0d expected 2 1", state, pass_count);
    end
    idle();
    do_arm(0);
    n_cmp++;
    if (state !== 2'd1 || pass_count !== 16'd0) begin
      n_bad++; $display("FAIL rearm: got st=%0d c=%0d expected 1 0", state, pass_count);
    end
  endtask

  task automatic test_arm_cancel();
    do_reset();
    cfg(K_SKIP, 5, 1, 9, 3, 777);
    cfg(K_SKIP, 2, 1, 9, 3, 500);
    do_arm(0);
    x_valid = 1; pc_x = 12'd9; pc_f = 12'd3; arm = 1;
    tick();
    arm = 0;
    n_cmp++;
    if (redir_valid !== 1'b0 || state !== 2'd1) begin
      n_bad++; $display("FAIL arm_cancel: got v=%b st=%0d expected 0 1", redir_valid, state);
    end
    tick();
    n_cmp++;
    if (redir_valid !== 1'b1 || redir_addr !== 12'd500) begin
      n_bad++; $display("FAIL skip_lowest: got v=%b a=%0d expected 1 500", redir_valid, redir_addr);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    cfg(K_PASS, 1, 1, 77);
    do_arm(0);
    drive_pass(77);
    tick();
    reset_n = 0;
    model_clear();
    #2;
    n_cmp++;
    if ({redir_valid, redir_addr, pass_hit, pass_idx, pass_count, state, timeout, fail_idx} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_run: got %h expected 0",
               {redir_valid, redir_addr, pass_hit, pass_idx, pass_count, state, timeout, fail_idx});
    end
    idle();
    @(posedge clk); #1;
    reset_n = 1;
    do_arm(0);
    drive_pass(77);
    tick();
    n_cmp++;
    if (pass_hit !== 1'b0) begin n_bad++; $display("FAIL table_cleared: got %b expected 0", pass_hit); end
  endtask

  task automatic test_random();
    logic [N_PASS-1:0] mcov;
    do_reset();
    for (int i = 0; i < 20; i++) cfg(K_PASS, $urandom_range(0, 63), $urandom_range(0, 4) != 0, $urandom_range(0, 15));
    for (int i = 0; i < 4; i++)
      cfg(K_SKIP, $urandom_range(0, 15), 1, $urandom_range(0, 63), $urandom_range(0, 3), $urandom_range(0, 4095));
    cfg(K_FAIL, $urandom_range(0, 7), 1, $urandom_range(0, 63));
    cfg(K_DONE, $urandom_range(0, 63), 1, $urandom_range(0, 63));
    do_arm(0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      arm     = ($urandom_range(0, 24) == 0);
      limit   = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
      x_valid = ($urandom_range(0, 4) != 0);
      pc_x    = PC_W'($urandom_range(0, 63));
      pc_f    = PC_W'($urandom_range(0, 3));
      op_sqi  = ($urandom_range(0, 1) == 0) ? 4'd14 : 4'($urandom_range(0, 15));
      op_map  = ($urandom_range(0, 3) != 0) ? 2'd0 : 2'($urandom_range(1, 3));
      op_a    = PC_W'($urandom_range(0, 15));
      cfg_we  = ($urandom_range(0, 19) == 0);
      cfg_kind = 2'($urandom_range(0, 3));
      cfg_idx = 6'($urandom_range(0, 63));
      cfg_en  = ($urandom_range(0, 3) != 0);
      cfg_a   = (cfg_kind == 2'd0) ? PC_W'($urandom_range(0, 15)) : PC_W'($urandom_range(0, 63));
      cfg_b   = PC_W'($urandom_range(0, 3));
      cfg_c   = PC_W'($urandom);
      tick();
      n_cmp++;
      if ({state, timeout, fail_idx, pass_count, pass_hit, pass_idx, redir_valid} !==
          {2'(m_state), m_tmo, 2'(m_fidx), 16'(m_pcnt), m_hit, 6'(m_pidx), m_redir}) begin
        n_bad++;
        $display("FAIL random_status cyc %0d: got st=%0d t=%b fi=%0d c=%0d h=%b i=%0d rv=%b expected st=%0d t=%b fi=%0d c=%0d h=%b i=%0d rv=%b",
                 cyc, state, timeout, fail_idx, pass_count, pass_hit, pass_idx, redir_valid,
                 m_state, m_tmo, m_fidx, m_pcnt, m_hit, m_pidx, m_redir);
      end
      if (m_redir) begin
        n_cmp++;
        if (redir_addr !== PC_W'(m_raddr)) begin
          n_bad++; $display("FAIL random_redir cyc %0d: got %0d expected %0d", cyc, redir_addr, m_raddr);
        end
      end
      foreach (m_cover[i]) mcov[i] = m_cover[i];
`ifdef UTEST_MONITOR_COVER_EN
      n_cmp++;
      if (cover_map !== mcov) begin
        n_bad++; $display("FAIL random_cover cyc %0d: got %h expected %h", cyc, cover_map, mcov);
      end
`endif
    end
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_skip();
    test_pass();
    test_repeat_hits();
    test_fail();
    test_timeout();
    test_done();
    test_arm_cancel();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
